mem_access: RTL and testbench

Memory-access stage sitting directly downstream of the EX/MEM pipeline register and upstream of MEM/WB. It turns the registered EX/MEM fields into a single req/ack transaction on the data-memory bus and generates byte lanes and store-data replication. It sign- or zero-extends load data and selects the write-back value. While a transaction is outstanding it raises `mem_stall`, which drives the EX/MEM `stop` input so that register holds.

---
 rtl/mem_access.sv | 162 ++++++++++++++++
 tb/tb_mem_access.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access stage: turns EX/MEM fields into one req/ack data-memory transaction,
// builds byte lanes and store replication, extends load data and selects the write-back value.
module mem_access #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stop,
    input  logic [31:0] mem_pc,
    input  logic        mem_DMWe,
    input  logic        mem_DMsign,
    input  logic [1:0]  mem_DMwidth,
    input  logic [31:0] mem_aluout,
    input  logic [31:0] mem_rfrdata2,
    input  logic        mem_RFWe,
    input  logic [1:0]  mem_RFWsrc,
    input  logic [4:0]  mem_rfwaddr,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        mem_stall,
    output logic [31:0] wb_data,
    output logic        wb_RFWe,
    output logic [4:0]  wb_rfwaddr,
    output logic        mem_misalign,
    output logic        mem_buserr
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [31:0] rdata_p1;
    logic        err_p1;
    logic        req_p1;

    logic        access;
    logic        misalign;
    logic        aligned_access;
    logic [31:0] load_val;

    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  width,
                                                 input logic [1:0]  lo,
                                                 input logic        sgn);
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        b  = 8'(word >> {lo, 3'b000});
        h  = lo[1] ? word[31:16] : word[15:0];
        sb = b;
        sh = h;
        case (width)
            2'b00:   extract_load = sgn ? 32'(sb) : {24'd0, b};
            2'b01:   extract_load = sgn ? 32'(sh) : {16'd0, h};
            default: extract_load = word;
        endcase
    endfunction

    assign access         = (mem_DMwidth != 2'b11);
    assign misalign       = ((mem_DMwidth == 2'b01) && mem_aluout[0]) ||
                            ((mem_DMwidth == 2'b10) && (mem_aluout[1:0] != 2'b00));
    assign aligned_access = access && !misalign;

    // Bus fields come straight from EX/MEM; the stall keeps them frozen during BUSY.
    assign dm_req  = req_p1;
    assign dm_we   = mem_DMWe;
    assign dm_addr = {mem_aluout[31:2], 2'b00};

    always_comb begin
        dm_be    = 4'b0000;
        dm_wdata = mem_rfrdata2;
        case (mem_DMwidth)
            2'b00: begin
                dm_be    = 4'b0001 << mem_aluout[1:0];
                dm_wdata = {4{mem_rfrdata2[7:0]}};
            end
            2'b01: begin
                dm_be    = mem_aluout[1] ? 4'b1100 : 4'b0011;
                dm_wdata = {2{mem_rfrdata2[15:0]}};
            end
            2'b10: begin
                dm_be    = 4'b1111;
                dm_wdata = mem_rfrdata2;
            end
            default: begin
                dm_be    = 4'b0000;
                dm_wdata = mem_rfrdata2;
            end
        endcase
    end

    // Transaction control: one bus request train per instruction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            rdata_p1 <= '0;
            err_p1   <= 1'b0;
            req_p1   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (aligned_access) begin
                        state    <= BUSY;
                        wait_cnt <= '0;
                        err_p1   <= 1'b0;
                        req_p1   <= 1'b1;
                    end
                end
                BUSY: begin
                    if (dm_ack) begin
                        rdata_p1 <= dm_rdata;
                        state    <= DONE;
                        req_p1   <= 1'b0;
                    end else if (wait_cnt == LAST_WAIT) begin
                        rdata_p1 <= '0;
                        err_p1   <= 1'b1;
                        state    <= DONE;
                        req_p1   <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    if (!stop) begin
                        state  <= IDLE;
                        err_p1 <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    req_p1 <= 1'b0;
                end
            endcase
        end
    end

    assign mem_stall    = aligned_access && (state != DONE);
    assign mem_misalign = misalign;
    assign mem_buserr   = err_p1;
    assign load_val     = extract_load(rdata_p1, mem_DMwidth, mem_aluout[1:0], mem_DMsign);

    always_comb begin
        case (mem_RFWsrc)
            2'b01:   wb_data = load_val;
            2'b10:   wb_data = mem_pc + 32'd4;
            default: wb_data = mem_aluout;
        endcase
    end

    assign wb_RFWe    = mem_RFWe && !misalign && !err_p1;
    assign wb_rfwaddr = mem_rfwaddr;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: lane generation, load extension, latency, timeout, hold and reset.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        stop;
    logic [31:0] mem_pc;
    logic        mem_DMWe;
    logic        mem_DMsign;
    logic [1:0]  mem_DMwidth;
    logic [31:0] mem_aluout;
    logic [31:0] mem_rfrdata2;
    logic        mem_RFWe;
    logic [1:0]  mem_RFWsrc;
    logic [4:0]  mem_rfwaddr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_stall;
    logic [31:0] wb_data;
    logic        wb_RFWe;
    logic [4:0]  wb_rfwaddr;
    logic        mem_misalign;
    logic        mem_buserr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst), .stop(stop), .mem_pc(mem_pc), .mem_DMWe(mem_DMWe),
        .mem_DMsign(mem_DMsign), .mem_DMwidth(mem_DMwidth), .mem_aluout(mem_aluout),
        .mem_rfrdata2(mem_rfrdata2), .mem_RFWe(mem_RFWe), .mem_RFWsrc(mem_RFWsrc),
        .mem_rfwaddr(mem_rfwaddr), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_stall(mem_stall), .wb_data(wb_data), .wb_RFWe(wb_RFWe), .wb_rfwaddr(wb_rfwaddr),
        .mem_misalign(mem_misalign), .mem_buserr(mem_buserr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic we, input logic sgn, input logic [1:0] width,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic rfwe, input logic [1:0] src);
        mem_DMWe = we; mem_DMsign = sgn; mem_DMwidth = width; mem_aluout = addr;
        mem_rfrdata2 = wd; mem_RFWe = rfwe; mem_RFWsrc = src;
        #1;
    endtask

    task automatic set_idle();
        set_instr(1'b0, 1'b0, 2'b11, 32'h0, 32'h0, 1'b0, 2'b00);
    endtask

    task automatic test_reset();
        rst = 1'b0; stop = 1'b0; dm_ack = 1'b0; dm_rdata = 32'h0;
        mem_pc = 32'h100; mem_rfwaddr = 5'd7;
        set_idle();
        step(); step();
        rst = 1'b1;
        #1;
        n_chk++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", dm_req); end
        n_chk++; if (mem_buserr !== 1'b0) begin n_fail++; $display("FAIL reset_buserr got %b want 0", mem_buserr); end
        n_chk++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", mem_stall); end
        n_chk++; if (wb_rfwaddr !== 5'd7) begin n_fail++; $display("FAIL reset_rfwaddr got %0d want 7", wb_rfwaddr); end
    endtask

    task automatic test_nonaccess();
        set_instr(1'b0, 1'b0, 2'b11, 32'h55, 32'h0, 1'b1, 2'b10);
        n_chk++; if (wb_data !== 32'h104) begin n_fail++; $display("FAIL pc4_data got %h want 00000104", wb_data); end
        n_chk++; if (wb_RFWe !== 1'b1 || mem_stall !== 1'b0 || mem_misalign !== 1'b0) begin
            n_fail++; $display("FAIL pc4_ctrl got we=%b stall=%b mis=%b want 1 0 0", wb_RFWe, mem_stall, mem_misalign); end
        mem_RFWsrc = 2'b11;
        #1;
        n_chk++; if (wb_data !== 32'h55) begin n_fail++; $display("FAIL rsv_src got %h want 00000055", wb_data); end
        step();
        n_chk++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL nonacc_req got %b want 0", dm_req); end
    endtask

    task automatic test_lb();
        int stalls;
        stalls = 0;
        set_instr(1'b0, 1'b1, 2'b00, 32'h1003, 32'h0, 1'b1, 2'b01);
        n_chk++; if (dm_be !== 4'b1000 || dm_addr !== 32'h1000) begin
            n_fail++; $display("FAIL lb_lane got be=%b addr=%h want 1000 00001000", dm_be, dm_addr); end
        n_chk++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL lb_arrive_req got %b want 0", dm_req); end
        if (mem_stall) stalls++;
        step();
        n_chk++; if (dm_req !== 1'b1) begin n_fail++; $display("FAIL lb_busy_req got %b want 1", dm_req); end
        if (mem_stall) stalls++;
        dm_ack = 1'b1; dm_rdata = 32'h80FF_FF12;
        step();
        dm_ack = 1'b0; dm_rdata = 32'h0;
        if (mem_stall) stalls++;
        n_chk++; if (stalls !== 2) begin n_fail++; $display("FAIL lb_stall_cycles got %0d want 2", stalls); end
        n_chk++; if (wb_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data got %h want ffffff80", wb_data); end
        n_chk++; if (dm_req !== 1'b0 || wb_RFWe !== 1'b1) begin
            n_fail++; $display("FAIL lb_done got req=%b we=%b want 0 1", dm_req, wb_RFWe); end
        step();
        set_idle();
    endtask

    task automatic test_sh();
        set_instr(1'b1, 1'b0, 2'b01, 32'h2002, 32'h1234_ABCD, 1'b0, 2'b00);
        n_chk++; if (dm_we !== 1'b1 || dm_be !== 4'b1100 || dm_wdata !== 32'hABCD_ABCD) begin
            n_fail++; $display("FAIL sh_lane got we=%b be=%b wd=%h want 1 1100 abcdabcd", dm_we, dm_be, dm_wdata); end
        step();
        n_chk++; if (dm_req !== 1'b1 || mem_stall !== 1'b1) begin
            n_fail++; $display("FAIL sh_busy got req=%b stall=%b want 1 1", dm_req, mem_stall); end
        dm_ack = 1'b1;
        step();
        dm_ack = 1'b0;
        n_chk++; if (mem_stall !== 1'b0 || wb_RFWe !== 1'b0) begin
            n_fail++; $display("FAIL sh_done got stall=%b we=%b want 0 0", mem_stall, wb_RFWe); end
        step();
        set_instr(1'b1, 1'b0, 2'b00, 32'h2001, 32'h0000_005A, 1'b0, 2'b00);
        n_chk++; if (dm_be !== 4'b0010 || dm_wdata !== 32'h5A5A_5A5A) begin
            n_fail++; $display("FAIL sb_lane got be=%b wd=%h want 0010 5a5a5a5a", dm_be, dm_wdata); end
        set_idle();
    endtask

    task automatic test_misalign();
        set_instr(1'b0, 1'b0, 2'b10, 32'h3001, 32'h0, 1'b1, 2'b01);
        n_chk++; if (mem_misalign !== 1'b1 || wb_RFWe !== 1'b0 || mem_stall !== 1'b0) begin
            n_fail++; $display("FAIL lw_mis got mis=%b we=%b stall=%b want 1 0 0", mem_misalign, wb_RFWe, mem_stall); end
        step();
        n_chk++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL lw_mis_req got %b want 0", dm_req); end
        set_instr(1'b0, 1'b0, 2'b01, 32'h3003, 32'h0, 1'b1, 2'b01);
        n_chk++; if (mem_misalign !== 1'b1 || mem_stall !== 1'b0) begin
            n_fail++; $display("FAIL lh_mis got mis=%b stall=%b want 1 0", mem_misalign, mem_stall); end
        set_idle();
    endtask

    task automatic test_timeout();
        int reqs;
        reqs = 0;
        set_instr(1'b0, 1'b0, 2'b10, 32'h4000, 32'h0, 1'b1, 2'b01);
        step();
        for (int i = 0; i < 10 && dm_req; i++) begin
            reqs++;
            step();
        end
        n_chk++; if (reqs !== 4) begin n_fail++; $display("FAIL to_req_cycles got %0d want 4", reqs); end
        n_chk++; if (mem_buserr !== 1'b1 || wb_RFWe !== 1'b0 || mem_stall !== 1'b0) begin
            n_fail++; $display("FAIL to_done got err=%b we=%b stall=%b want 1 0 0", mem_buserr, wb_RFWe, mem_stall); end
        n_chk++; if (wb_data !== 32'h0) begin n_fail++; $display("FAIL to_data got %h want 00000000", wb_data); end
        step();
        set_idle();
        n_chk++; if (mem_buserr !== 1'b0) begin n_fail++; $display("FAIL to_clear got %b want 0", mem_buserr); end
    endtask

    task automatic test_hold();
        int reqs;
        reqs = 0;
        set_instr(1'b0, 1'b0, 2'b01, 32'h10, 32'h0, 1'b1, 2'b01);
        step();
        for (int i = 0; i < 3; i++) begin
            if (dm_req) reqs++;
            step();
        end
        if (dm_req) reqs++;
        dm_ack = 1'b1; dm_rdata = 32'h1111_F00D;
        step();
        dm_ack = 1'b0; dm_rdata = 32'h0;
        stop = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (dm_req) reqs++;
            n_chk++; if (wb_data !== 32'h0000_F00D || mem_stall !== 1'b0) begin
                n_fail++; $display("FAIL hold_data cyc%0d got %h stall=%b want 0000f00d 0", i, wb_data, mem_stall); end
            step();
        end
        n_chk++; if (reqs !== 4) begin n_fail++; $display("FAIL hold_req_cycles got %0d want 4", reqs); end
        stop = 1'b0;
        #1;
        n_chk++; if (mem_stall !== 1'b0 || dm_req !== 1'b0) begin
            n_fail++; $display("FAIL hold_still_done got stall=%b req=%b want 0 0", mem_stall, dm_req); end
        step();
        n_chk++; if (mem_stall !== 1'b1 || dm_req !== 1'b0) begin
            n_fail++; $display("FAIL hold_idle got stall=%b req=%b want 1 0", mem_stall, dm_req); end
        set_idle();
    endtask

    task automatic test_back_to_back();
        set_instr(1'b0, 1'b1, 2'b01, 32'h6002, 32'h0, 1'b1, 2'b01);
        step();
        dm_ack = 1'b1; dm_rdata = 32'h8001_1234;
        step();
        dm_ack = 1'b0;
        n_chk++; if (wb_data !== 32'hFFFF_8001) begin n_fail++; $display("FAIL b2b_lh got %h want ffff8001", wb_data); end
        step();
        set_instr(1'b0, 1'b0, 2'b10, 32'h6004, 32'h0, 1'b1, 2'b01);
        n_chk++; if (dm_req !== 1'b0 || mem_stall !== 1'b1) begin
            n_fail++; $display("FAIL b2b_gap got req=%b stall=%b want 0 1", dm_req, mem_stall); end
        step();
        n_chk++; if (dm_req !== 1'b1) begin n_fail++; $display("FAIL b2b_req2 got %b want 1", dm_req); end
        dm_ack = 1'b1; dm_rdata = 32'h0123_4567;
        step();
        dm_ack = 1'b0;
        n_chk++; if (wb_data !== 32'h0123_4567) begin n_fail++; $display("FAIL b2b_lw got %h want 01234567", wb_data); end
        step();
        set_idle();
    endtask

    task automatic test_reset_busy();
        set_instr(1'b0, 1'b0, 2'b10, 32'h5000, 32'h0, 1'b1, 2'b01);
        step();
        n_chk++; if (dm_req !== 1'b1) begin n_fail++; $display("FAIL rb_busy got %b want 1", dm_req); end
        rst = 1'b0;
        step();
        rst = 1'b1;
        set_instr(1'b0, 1'b0, 2'b11, 32'h0, 32'h0, 1'b1, 2'b01);
        n_chk++; if (dm_req !== 1'b0 || mem_buserr !== 1'b0) begin
            n_fail++; $display("FAIL rb_abort got req=%b err=%b want 0 0", dm_req, mem_buserr); end
        dm_ack = 1'b1; dm_rdata = 32'hDEAD_BEEF;
        step();
        dm_ack = 1'b0;
        n_chk++; if (wb_data !== 32'h0 || dm_req !== 1'b0) begin
            n_fail++; $display("FAIL rb_late_ack got data=%h req=%b want 00000000 0", wb_data, dm_req); end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_nonaccess();
        test_lb();
        test_sh();
        test_misalign();
        test_timeout();
        test_hold();
        test_back_to_back();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
